uart_axil_master: RTL and testbench

//  UART debug bridge: AXI-lite *initiator* driven by a byte-stream command protocol from a host PC.

---
 rtl/uart_axil_master_pkg.sv | 35 +++
 rtl/axil_master_port.sv | 137 +++++++++++++
 rtl/uart_axil_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_axil_master.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_axil_master_pkg.sv
// Shared constants, state encoding and command payload for the UART-to-AXI-lite debug bridge.
package uart_axil_master_pkg;

    localparam int unsigned WIRE_AW = 32;
    localparam int unsigned DATA_W  = 32;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;
    localparam logic [7:0] RSP_BAD   = 8'h3F;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_AXI_REQ,
        ST_AXI_RESP,
        ST_SEND
    } uart_axil_mst_state_t;

    // One fully parsed command handed to the AXI-lite port
    typedef struct packed {
        logic               write;
        logic [WIRE_AW-1:0] addr;
        logic [DATA_W-1:0]  wdata;
    } axil_cmd_t;

    function automatic logic [7:0] resp_to_byte(input logic [1:0] resp);
        return (resp == AXI_RESP_OKAY) ? RSP_OK : RSP_ERR;
    endfunction

endpackage

// File: rtl/axil_master_port.sv
// Single-transaction AXI-lite initiator: holds AW/W/AR valids until accepted, then captures B or R.
module axil_master_port
    import uart_axil_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  axil_cmd_t             cmd_i,
    output logic                  req_done_o,
    output logic                  done_o,
    output logic [1:0]            resp_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic [2:0]            awprot_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [3:0]            wstrb_o,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    input  logic [1:0]            bresp_i,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [2:0]            arprot_o,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [1:0]            rresp_i
);

    axil_cmd_t         cmd_q, cmd_d;
    logic              req_q, req_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              req_done_q, req_done_d;
    logic              done_q, done_d;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Request phase ends only when every raised valid has seen its own handshake
    always_comb begin
        cmd_d      = cmd_q;
        req_d      = req_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        bready_d   = bready_q;
        rready_d   = rready_q;
        req_done_d = 1'b0;
        done_d     = 1'b0;
        resp_d     = resp_q;
        rdata_d    = rdata_q;

        if (start_i) begin
            cmd_d     = cmd_i;
            req_d     = 1'b1;
            awvalid_d = cmd_i.write;
            wvalid_d  = cmd_i.write;
            arvalid_d = !cmd_i.write;
        end else if (req_q) begin
            if (awvalid_q && awready_i) awvalid_d = 1'b0;
            if (wvalid_q && wready_i)   wvalid_d  = 1'b0;
            if (arvalid_q && arready_i) arvalid_d = 1'b0;
            if (!awvalid_d && !wvalid_d && !arvalid_d) begin
                req_d      = 1'b0;
                req_done_d = 1'b1;
                bready_d   = cmd_q.write;
                rready_d   = !cmd_q.write;
            end
        end

        if (bready_q && bvalid_i) begin
            bready_d = 1'b0;
            resp_d   = bresp_i;
            done_d   = 1'b1;
        end
        if (rready_q && rvalid_i) begin
            rready_d = 1'b0;
            resp_d   = rresp_i;
            rdata_d  = rdata_i;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q      <= '0;
            req_q      <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            req_done_q <= 1'b0;
            done_q     <= 1'b0;
            resp_q     <= 2'b00;
            rdata_q    <= '0;
        end else begin
            cmd_q      <= cmd_d;
            req_q      <= req_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            bready_q   <= bready_d;
            rready_q   <= rready_d;
            req_done_q <= req_done_d;
            done_q     <= done_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign req_done_o = req_done_q;
    assign done_o     = done_q;
    assign resp_o     = resp_q;
    assign rdata_o    = rdata_q;
    assign awvalid_o  = awvalid_q;
    assign awaddr_o   = cmd_q.addr[ADDR_WIDTH-1:0];
    assign awprot_o   = 3'b000;
    assign wvalid_o   = wvalid_q;
    assign wdata_o    = cmd_q.wdata;
    assign wstrb_o    = {4{wvalid_q}};
    assign bready_o   = bready_q;
    assign arvalid_o  = arvalid_q;
    assign araddr_o   = cmd_q.addr[ADDR_WIDTH-1:0];
    assign arprot_o   = 3'b000;
    assign rready_o   = rready_q;

endmodule

// File: rtl/uart_axil_master.sv
// UART byte-stream command parser driving a single-beat AXI-lite initiator port.
// Optional inter-byte timeout enabled by defining UART_AXIL_MST_TIMEOUT_EN.
module uart_axil_master
    import uart_axil_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic [2:0]            awprot_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [31:0]           wdata_o,
    output logic [3:0]            wstrb_o,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    input  logic [1:0]            bresp_i,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [2:0]            arprot_o,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp_i,
    output logic                  busy_o,
    output logic                  rx_drop_o
);

    uart_axil_mst_state_t state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [WIRE_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 start_q, start_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 rx_drop_q, rx_drop_d;
    logic                 busy_q, busy_d;

    logic                 port_req_done;
    logic                 port_done;
    logic [1:0]           port_resp;
    logic [DATA_W-1:0]    port_rdata;
    logic                 tmo_hit_c;
    axil_cmd_t            cmd_c;

    assign cmd_c = '{write: wr_q, addr: addr_q, wdata: data_q};

`ifdef UART_AXIL_MST_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             collecting_c;

    assign collecting_c = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign tmo_hit_c    = collecting_c && !rx_valid_i && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Idle-gap counter, restarted by every received byte
    always_comb begin
        tmo_d = tmo_q;
        if (!collecting_c || rx_valid_i) tmo_d = '0;
        else                             tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    logic [31:0] tmo_unused_c;

    assign tmo_unused_c = 32'(TIMEOUT_CYCLES);
    assign tmo_hit_c    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        start_d    = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rx_drop_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    cnt_d = 3'd0;
                    if (rx_data_i == CMD_WRITE) begin
                        wr_d    = 1'b1;
                        state_d = ST_GET_ADDR;
                    end else if (rx_data_i == CMD_READ) begin
                        wr_d    = 1'b0;
                        state_d = ST_GET_ADDR;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = RSP_BAD;
                        state_d    = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = {addr_q[23:0], rx_data_i};
                    if (cnt_q == 3'd3) begin
                        cnt_d   = 3'd0;
                        state_d = wr_q ? ST_GET_DATA : ST_AXI_REQ;
                        start_d = !wr_q;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_GET_DATA: begin
                if (rx_valid_i) begin
                    data_d = {data_q[23:0], rx_data_i};
                    if (cnt_q == 3'd3) begin
                        cnt_d   = 3'd0;
                        state_d = ST_AXI_REQ;
                        start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_AXI_REQ: begin
                rx_drop_d = rx_valid_i;
                if (port_req_done) state_d = ST_AXI_RESP;
            end
            ST_AXI_RESP: begin
                rx_drop_d = rx_valid_i;
                // Status byte goes out first; read data is queued behind it MSB first
                if (port_done) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = resp_to_byte(port_resp);
                    data_d     = port_rdata;
                    cnt_d      = wr_q ? 3'd0 : 3'd4;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                rx_drop_d = rx_valid_i;
                if (tx_valid_q && tx_ready_i) begin
                    if (cnt_q == 3'd0) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d     = cnt_q - 3'd1;
                        tx_data_d = data_q[31:24];
                        data_d    = {data_q[23:0], 8'h00};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_hit_c) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            start_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_drop_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            start_q    <= start_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_drop_q  <= rx_drop_d;
            busy_q     <= busy_d;
        end
    end

    axil_master_port #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_q),
        .cmd_i      (cmd_c),
        .req_done_o (port_req_done),
        .done_o     (port_done),
        .resp_o     (port_resp),
        .rdata_o    (port_rdata),
        .awvalid_o  (awvalid_o),
        .awready_i  (awready_i),
        .awaddr_o   (awaddr_o),
        .awprot_o   (awprot_o),
        .wvalid_o   (wvalid_o),
        .wready_i   (wready_i),
        .wdata_o    (wdata_o),
        .wstrb_o    (wstrb_o),
        .bvalid_i   (bvalid_i),
        .bready_o   (bready_o),
        .bresp_i    (bresp_i),
        .arvalid_o  (arvalid_o),
        .arready_i  (arready_i),
        .araddr_o   (araddr_o),
        .arprot_o   (arprot_o),
        .rvalid_i   (rvalid_i),
        .rready_o   (rready_o),
        .rdata_i    (rdata_i),
        .rresp_i    (rresp_i)
    );

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign rx_drop_o  = rx_drop_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_axil_master.sv
// Directed bench for uart_axil_master with a small AXI-lite slave and TX byte collector.
module tb_uart_axil_master;

    logic        clk;
    logic        rst;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        awvalid_o, awready_i;
    logic [31:0] awaddr_o;
    logic [2:0]  awprot_o;
    logic        wvalid_o, wready_i;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        bvalid_i, bready_o;
    logic [1:0]  bresp_i;
    logic        arvalid_o, arready_i;
    logic [31:0] araddr_o;
    logic [2:0]  arprot_o;
    logic        rvalid_i, rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        busy_o;
    logic        rx_drop_o;

    int checks = 0;
    int errors = 0;

    // slave configuration
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;

    // monitor state
    int          cyc = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    int          aw_cyc = 0, w_cyc = 0;
    int          drop_cnt = 0, valid_cycles = 0;
    logic [31:0] last_awaddr, last_wdata, last_araddr;
    logic [3:0]  last_wstrb;
    logic [2:0]  last_awprot, last_arprot;
    logic [7:0]  txq[$];

    uart_axil_master #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i),
        .awvalid_o  (awvalid_o),
        .awready_i  (awready_i),
        .awaddr_o   (awaddr_o),
        .awprot_o   (awprot_o),
        .wvalid_o   (wvalid_o),
        .wready_i   (wready_i),
        .wdata_o    (wdata_o),
        .wstrb_o    (wstrb_o),
        .bvalid_i   (bvalid_i),
        .bready_o   (bready_o),
        .bresp_i    (bresp_i),
        .arvalid_o  (arvalid_o),
        .arready_i  (arready_i),
        .araddr_o   (araddr_o),
        .arprot_o   (arprot_o),
        .rvalid_i   (rvalid_i),
        .rready_o   (rready_o),
        .rdata_i    (rdata_i),
        .rresp_i    (rresp_i),
        .busy_o     (busy_o),
        .rx_drop_o  (rx_drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: ready after a configurable wait; B/R valid once the request side has completed
    int aw_wait = 0, w_wait = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (awvalid_o) begin
                if (aw_wait >= aw_delay) awready_i = 1'b1;
                else aw_wait++;
            end else begin
                awready_i = 1'b0;
                aw_wait   = 0;
            end
            if (wvalid_o) begin
                if (w_wait >= w_delay) wready_i = 1'b1;
                else w_wait++;
            end else begin
                wready_i = 1'b0;
                w_wait   = 0;
            end
            arready_i = arvalid_o;
            bvalid_i  = (aw_hs == w_hs) && (aw_hs > b_hs);
            bresp_i   = bresp_cfg;
            rvalid_i  = (ar_hs > r_hs);
            rresp_i   = rresp_cfg;
            rdata_i   = rvalid_i ? rdata_cfg : 32'h0;
        end
    end

    // Monitor samples 1 time unit before each rising edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (awvalid_o && awready_i) begin
                aw_hs++; aw_cyc = cyc; last_awaddr = awaddr_o; last_awprot = awprot_o;
            end
            if (wvalid_o && wready_i) begin
                w_hs++; w_cyc = cyc; last_wdata = wdata_o; last_wstrb = wstrb_o;
            end
            if (arvalid_o && arready_i) begin
                ar_hs++; last_araddr = araddr_o; last_arprot = arprot_o;
            end
            if (bvalid_i && bready_o) b_hs++;
            if (rvalid_i && rready_o) r_hs++;
            if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
            if (rx_drop_o) drop_cnt++;
            if (awvalid_o || wvalid_o || arvalid_o) valid_cycles++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy_o=%b after %0d cycles, expected 0", name, busy_o, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_valid_o, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b expected 000000",
                     {tx_valid_o, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o});
        end
        checks++;
        if ({busy_o, rx_drop_o} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_drop: got %b expected 00", {busy_o, rx_drop_o});
        end
        checks++;
        if (wstrb_o !== 4'h0 || tx_data_o !== 8'h00) begin
            errors++; $display("FAIL reset_data: wstrb=%h tx_data=%h expected 0 0", wstrb_o, tx_data_o);
        end
        checks++;
        if (awaddr_o !== 32'h0 || wdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_addr: awaddr=%h wdata=%h expected 0 0", awaddr_o, wdata_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_write();
        int aw0 = aw_hs, w0 = w_hs;
        logic [7:0] cmd[9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        txq.delete();
        bresp_cfg = 2'b00;
        foreach (cmd[i]) send_byte(cmd[i]);
        wait_idle("write");
        checks++;
        if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
            errors++; $display("FAIL write_hs: aw=%0d w=%0d expected 1 1", aw_hs - aw0, w_hs - w0);
        end
        checks++;
        if (last_awaddr !== 32'h4) begin
            errors++; $display("FAIL write_awaddr: got %h expected 00000004", last_awaddr);
        end
        checks++;
        if (last_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_wdata: got %h expected deadbeef", last_wdata);
        end
        checks++;
        if (last_wstrb !== 4'hF || last_awprot !== 3'b000) begin
            errors++; $display("FAIL write_strb_prot: got %h %b expected f 000", last_wstrb, last_awprot);
        end
        checks++;
        if (txq.size() !== 1) begin
            errors++; $display("FAIL write_tx_count: got %0d expected 1", txq.size());
        end else begin
            checks++;
            if (txq[0] !== 8'h4B) begin
                errors++; $display("FAIL write_tx_byte: got %h expected 4b", txq[0]);
            end
        end
    endtask

    task automatic test_read();
        int ar0 = ar_hs;
        logic [7:0] cmd[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
        logic [7:0] exp_tx[5] = '{8'h4B, 8'h12, 8'h34, 8'h56, 8'h78};
        txq.delete();
        rdata_cfg = 32'h12345678;
        rresp_cfg = 2'b00;
        foreach (cmd[i]) send_byte(cmd[i]);
        wait_idle("read");
        checks++;
        if (ar_hs - ar0 !== 1) begin
            errors++; $display("FAIL read_ar_hs: got %0d expected 1", ar_hs - ar0);
        end
        checks++;
        if (last_araddr !== 32'h8 || last_arprot !== 3'b000) begin
            errors++; $display("FAIL read_araddr: got %h prot %b expected 00000008 000", last_araddr, last_arprot);
        end
        checks++;
        if (txq.size() !== 5) begin
            errors++; $display("FAIL read_tx_count: got %0d expected 5", txq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (txq[i] !== exp_tx[i]) begin
                    errors++; $display("FAIL read_tx_byte%0d: got %h expected %h", i, txq[i], exp_tx[i]);
                end
            end
        end
    endtask

    task automatic test_split_handshake();
        int aw0 = aw_hs, w0 = w_hs;
        logic [7:0] cmd[9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04};
        txq.delete();
        aw_delay  = 0;
        w_delay   = 1;
        bresp_cfg = 2'b10;
        foreach (cmd[i]) send_byte(cmd[i]);
        wait_idle("split");
        checks++;
        if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
            errors++; $display("FAIL split_hs: aw=%0d w=%0d expected 1 1", aw_hs - aw0, w_hs - w0);
        end
        checks++;
        if (w_cyc - aw_cyc !== 1) begin
            errors++; $display("FAIL split_order: w-aw cycle gap %0d expected 1", w_cyc - aw_cyc);
        end
        checks++;
        if (last_wdata !== 32'h01020304 || last_awaddr !== 32'h10) begin
            errors++; $display("FAIL split_payload: got %h @%h expected 01020304 @00000010", last_wdata, last_awaddr);
        end
        checks++;
        if (txq.size() !== 1) begin
            errors++; $display("FAIL split_tx_count: got %0d expected 1", txq.size());
        end else begin
            checks++;
            if (txq[0] !== 8'h45) begin
                errors++; $display("FAIL split_tx_byte: got %h expected 45", txq[0]);
            end
        end
        w_delay   = 0;
        bresp_cfg = 2'b00;
    endtask

    task automatic test_backpressure_drop();
        int d0 = drop_cnt;
        int n = 0;
        logic [7:0] cmd[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h0C};
        logic [7:0] exp_tx[5] = '{8'h4B, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
        txq.delete();
        rdata_cfg  = 32'hA5A55A5A;
        tx_ready_i = 1'b0;
        foreach (cmd[i]) send_byte(cmd[i]);
        while (!tx_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_valid_o !== 1'b1) begin
            errors++; $display("FAIL bp_tx_valid_timeout: got %b expected 1", tx_valid_o);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h4B) begin
                errors++; $display("FAIL bp_hold_%0d: valid=%b data=%h expected 1 4b", i, tx_valid_o, tx_data_o);
            end
            rx_valid_i = (i == 5);
            rx_data_i  = 8'h11;
        end
        rx_valid_i = 1'b0;
        checks++;
        if (drop_cnt - d0 !== 1) begin
            errors++; $display("FAIL bp_drop_count: got %0d expected 1", drop_cnt - d0);
        end
        tx_ready_i = 1'b1;
        wait_idle("bp");
        checks++;
        if (txq.size() !== 5) begin
            errors++; $display("FAIL bp_tx_count: got %0d expected 5", txq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (txq[i] !== exp_tx[i]) begin
                    errors++; $display("FAIL bp_tx_byte%0d: got %h expected %h", i, txq[i], exp_tx[i]);
                end
            end
        end
    endtask

    task automatic test_bad_opcode();
        int v0 = valid_cycles;
        txq.delete();
        send_byte(8'h00);
        wait_idle("bad");
        checks++;
        if (txq.size() !== 1) begin
            errors++; $display("FAIL bad_tx_count: got %0d expected 1", txq.size());
        end else begin
            checks++;
            if (txq[0] !== 8'h3F) begin
                errors++; $display("FAIL bad_tx_byte: got %h expected 3f", txq[0]);
            end
        end
        checks++;
        if (valid_cycles - v0 !== 0) begin
            errors++; $display("FAIL bad_axi_valid: got %0d valid cycles expected 0", valid_cycles - v0);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL bad_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_timeout();
        int aw0 = aw_hs, ar0 = ar_hs;
        txq.delete();
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (150) @(negedge clk);
        checks++;
        if (txq.size() !== 0 || aw_hs - aw0 !== 0 || ar_hs - ar0 !== 0) begin
            errors++; $display("FAIL tmo_quiet: tx=%0d aw=%0d ar=%0d expected 0 0 0",
                               txq.size(), aw_hs - aw0, ar_hs - ar0);
        end
`ifdef UART_AXIL_MST_TIMEOUT_EN
        begin
            logic [7:0] cmd[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
            checks++;
            if (busy_o !== 1'b0) begin
                errors++; $display("FAIL tmo_idle: busy=%b expected 0", busy_o);
            end
            rdata_cfg = 32'h0BADF00D;
            foreach (cmd[i]) send_byte(cmd[i]);
            wait_idle("tmo_read");
            checks++;
            if (last_araddr !== 32'h8 || ar_hs - ar0 !== 1) begin
                errors++; $display("FAIL tmo_read_addr: got %h hs %0d expected 00000008 1", last_araddr, ar_hs - ar0);
            end
            checks++;
            if (txq.size() !== 5 || txq[0] !== 8'h4B || txq[4] !== 8'h0D) begin
                errors++; $display("FAIL tmo_read_tx: count %0d expected 5 starting 4b ending 0d", txq.size());
            end
        end
`else
        begin
            logic [7:0] rest[7] = '{8'h00, 8'h00, 8'h20, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
            checks++;
            if (busy_o !== 1'b1) begin
                errors++; $display("FAIL wait_busy: busy=%b expected 1", busy_o);
            end
            foreach (rest[i]) send_byte(rest[i]);
            wait_idle("late_write");
            checks++;
            if (last_awaddr !== 32'h20 || last_wdata !== 32'hCAFEBABE || aw_hs - aw0 !== 1) begin
                errors++; $display("FAIL late_write_payload: got %h @%h hs %0d expected cafebabe @00000020 1",
                                   last_wdata, last_awaddr, aw_hs - aw0);
            end
            checks++;
            if (txq.size() !== 1 || txq[0] !== 8'h4B) begin
                errors++; $display("FAIL late_write_tx: count %0d expected 1 byte 4b", txq.size());
            end
        end
`endif
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b1;
        awready_i  = 1'b0;
        wready_i   = 1'b0;
        bvalid_i   = 1'b0;
        bresp_i    = 2'b00;
        arready_i  = 1'b0;
        rvalid_i   = 1'b0;
        rdata_i    = 32'h0;
        rresp_i    = 2'b00;

        test_reset();
        test_write();
        test_read();
        test_split_handshake();
        test_backpressure_drop();
        test_bad_opcode();
        test_timeout();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
